// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - execute-stage multiply/divide unit producing HI/LO and the mult_ok stall signal
module multdiv_unit #(
  parameter int MULT_CYCLES = 2,
  parameter int DIV_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        hold,
  output logic        ok,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateT;

  stateT       state;
  logic [4:0]  count;
  logic        isSigned;
  logic [31:0] aReg;
  logic [31:0] bReg;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] divisor;

  // op[0]=0 selects the signed flavour (MULT/DIV)
  logic        startSigned;
  logic [31:0] aMag;
  logic [31:0] bMag;

  logic [63:0] mulA;
  logic [63:0] mulB;
  logic [63:0] product;

  logic [32:0] shifted;
  logic        noBorrow;
  logic [31:0] remSub;
  logic [31:0] newRem;
  logic [31:0] newQuo;
  logic        negQuo;
  logic        negRem;
  logic        divZero;

  assign ok   = (state == IDLE && !valid) || state == DONE;
  assign busy = (state == MUL) || (state == DIV);

  assign startSigned = ~op[0];
  assign aMag = (startSigned && a[31]) ? (32'd0 - a) : a;
  assign bMag = (startSigned && b[31]) ? (32'd0 - b) : b;

  // Sign/zero extension to 64 bits makes the low 64 product bits correct for both flavours
  assign mulA    = {{32{isSigned & aReg[31]}}, aReg};
  assign mulB    = {{32{isSigned & bReg[31]}}, bReg};
  assign product = mulA * mulB;

  // One restoring step: remainder stays below divisor, so the subtraction fits 32 bits
  assign shifted  = {rem, quo[31]};
  assign noBorrow = shifted >= {1'b0, divisor};
  assign remSub   = shifted[31:0] - divisor;
  assign newRem   = noBorrow ? remSub : shifted[31:0];
  assign newQuo   = {quo[30:0], noBorrow};

  assign negQuo  = isSigned & (aReg[31] ^ bReg[31]);
  assign negRem  = isSigned & aReg[31];
  assign divZero = (bReg == 32'd0);

  // Control FSM with operand latching, iteration datapath and HI/LO result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= 5'd0;
      isSigned <= 1'b0;
      aReg     <= 32'd0;
      bReg     <= 32'd0;
      rem      <= 32'd0;
      quo      <= 32'd0;
      divisor  <= 32'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else if (flush) begin
      state <= IDLE;
      count <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            isSigned <= startSigned;
            aReg     <= a;
            bReg     <= b;
            if (op[1]) begin
              state   <= DIV;
              count   <= 5'(DIV_CYCLES - 1);
              rem     <= 32'd0;
              quo     <= aMag;
              divisor <= bMag;
            end else begin
              state <= MUL;
              count <= 5'(MULT_CYCLES - 1);
            end
          end
        end
        MUL: begin
          if (count == 5'd0) begin
            hi    <= product[63:32];
            lo    <= product[31:0];
            state <= DONE;
          end else begin
            count <= count - 5'd1;
          end
        end
        DIV: begin
          rem <= newRem;
          quo <= newQuo;
          if (count == 5'd0) begin
            if (divZero) begin
              lo <= 32'hFFFF_FFFF;
              hi <= aReg;
            end else begin
              lo <= negQuo ? (32'd0 - newQuo) : newQuo;
              hi <= negRem ? (32'd0 - newRem) : newRem;
            end
            state <= DONE;
          end else begin
            count <= count - 5'd1;
          end
        end
        DONE: begin
          if (!hold) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
